// File: rtl/print_seq.sv
// Printer sequencer: issues NUM_MSG consecutive string IDs to a printer, one start
// pulse per string, waiting for printer_done between strings, with optional timeout.
module print_seq #(
    parameter int unsigned STR_ID_W       = 4,
    parameter int unsigned NUM_MSG        = 3,
    parameter int unsigned FIRST_ID       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    localparam int unsigned MSG_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                abort,
    input  logic                printer_done,
    output logic [STR_ID_W-1:0] printer_str_id,
    output logic                printer_enable,
    output logic [2:0]          seq_state,
    output logic                seq_done,
    output logic                seq_error,
    output logic [MSG_W-1:0]    msg_index
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [MSG_W-1:0]    MSG_LAST  = MSG_W'(NUM_MSG - 1);
    localparam logic [STR_ID_W-1:0] ID_FIRST  = STR_ID_W'(FIRST_ID);
    localparam bit                  TO_ENABLE = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [MSG_W-1:0]    msg_index_q, msg_index_d;
    logic [STR_ID_W-1:0] str_id_q, str_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pen_q, pen_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Next-state and registered-output decode; abort outranks every other transition.
    always_comb begin
        state_d     = state_q;
        msg_index_d = msg_index_q;
        str_id_d    = str_id_q;
        cnt_d       = cnt_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && !abort) begin
                        state_d     = S_ISSUE;
                        msg_index_d = '0;
                        str_id_d    = ID_FIRST;
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
                S_WAIT: begin
                    if (printer_done) begin
                        if (msg_index_q == MSG_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_ISSUE;
                            msg_index_d = msg_index_q + MSG_W'(1);
                            str_id_d    = str_id_q + STR_ID_W'(1);
                        end
                    end else if (TO_ENABLE) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_ERROR;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_ERROR: begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        pen_d  = (state_d == S_ISSUE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            msg_index_q <= '0;
            str_id_q    <= ID_FIRST;
            cnt_q       <= '0;
            pen_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_index_q <= msg_index_d;
            str_id_q    <= str_id_d;
            cnt_q       <= cnt_d;
            pen_q       <= pen_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign seq_state      = state_q;
    assign msg_index      = msg_index_q;
    assign printer_str_id = str_id_q;
    assign printer_enable = pen_q;
    assign seq_done       = done_q;
    assign seq_error      = err_q;

endmodule

// File: tb/tb_print_seq.sv
// Directed bench for print_seq: a per-cycle vector table on the default configuration,
// plus hand sequences for single-message, ID wrap, timeout and asynchronous reset.
module tb_print_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic abort = 1'b0;
    logic printer_done = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] id0, id1, id2;
    logic       pen0, pen1, pen2;
    logic [2:0] st0, st1, st2;
    logic       dn0, dn1, dn2;
    logic       er0, er1, er2;
    logic [1:0] idx0;
    logic [0:0] idx1;
    logic [1:0] idx2;

    print_seq dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort), .printer_done(printer_done),
        .printer_str_id(id0), .printer_enable(pen0), .seq_state(st0), .seq_done(dn0),
        .seq_error(er0), .msg_index(idx0)
    );

    print_seq #(.STR_ID_W(4), .NUM_MSG(1), .FIRST_ID(15), .TIMEOUT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort), .printer_done(printer_done),
        .printer_str_id(id1), .printer_enable(pen1), .seq_state(st1), .seq_done(dn1),
        .seq_error(er1), .msg_index(idx1)
    );

    print_seq #(.STR_ID_W(4), .NUM_MSG(3), .FIRST_ID(14), .TIMEOUT_CYCLES(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort), .printer_done(printer_done),
        .printer_str_id(id2), .printer_enable(pen2), .seq_state(st2), .seq_done(dn2),
        .seq_error(er2), .msg_index(idx2)
    );

    typedef struct {
        logic       en, ab, dn;
        logic [2:0] st;
        logic       pen;
        logic [3:0] id;
        logic [1:0] idx;
        logic       done, err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(logic en, logic ab, logic dn, logic [2:0] st, logic pen,
                                logic [3:0] id, logic [1:0] idx, logic done, logic err);
        vec_t v;
        v.en = en; v.ab = ab; v.dn = dn; v.st = st; v.pen = pen;
        v.id = id; v.idx = idx; v.done = done; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Apply inputs, advance one rising edge, then settle before sampling.
    task automatic step(input logic en, input logic ab, input logic dn);
        enable = en; abort = ab; printer_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 0; abort = 0; printer_done = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic chk2(input string nm, input logic [2:0] st, input logic pen,
                        input logic [3:0] id, input logic done, input logic err);
        chk({nm, "_state"}, 32'(st2), 32'(st));
        chk({nm, "_pen"}, 32'(pen2), 32'(pen));
        chk({nm, "_id"}, 32'(id2), 32'(id));
        chk({nm, "_done"}, 32'(dn2), 32'(done));
        chk({nm, "_err"}, 32'(er2), 32'(err));
    endtask

    initial begin
        //  en ab dn  st pen id idx done err
        add(1, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 1,  2, 0, 0, 0, 0, 0);
        add(0, 0, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 1,  1, 1, 1, 1, 0, 0);
        add(0, 0, 1,  2, 0, 1, 1, 0, 0);
        add(0, 0, 1,  1, 1, 2, 2, 0, 0);
        add(0, 0, 0,  2, 0, 2, 2, 0, 0);
        add(0, 0, 1,  3, 0, 2, 2, 1, 0);
        add(0, 0, 0,  0, 0, 2, 2, 0, 0);
        add(1, 1, 0,  0, 0, 2, 2, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 1,  1, 1, 1, 1, 0, 0);
        add(0, 0, 0,  2, 0, 1, 1, 0, 0);
        add(0, 1, 1,  0, 0, 1, 1, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 1,  2, 0, 0, 0, 0, 0);
        add(0, 0, 1,  1, 1, 1, 1, 0, 0);
        add(0, 0, 1,  2, 0, 1, 1, 0, 0);
        add(0, 0, 1,  1, 1, 2, 2, 0, 0);
        add(0, 0, 1,  2, 0, 2, 2, 0, 0);
        add(1, 0, 1,  3, 0, 2, 2, 1, 0);
        add(1, 0, 0,  0, 0, 2, 2, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 1, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 1,  1, 1, 1, 1, 0, 0);
        add(0, 0, 0,  2, 0, 1, 1, 0, 0);
        add(0, 0, 1,  1, 1, 2, 2, 0, 0);
        add(0, 0, 0,  2, 0, 2, 2, 0, 0);
        add(0, 0, 1,  3, 0, 2, 2, 1, 0);
        add(0, 1, 0,  0, 0, 2, 2, 0, 0);

        // Reset values of the default instance
        do_reset();
        chk("rst_state", 32'(st0), 32'd0);
        chk("rst_pen", 32'(pen0), 32'd0);
        chk("rst_id", 32'(id0), 32'd0);
        chk("rst_idx", 32'(idx0), 32'd0);
        chk("rst_done_err", 32'({dn0, er0}), 32'd0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].ab, vecs[i].dn);
            checks++;
            if ({st0, pen0, id0, idx0, dn0, er0} !==
                {vecs[i].st, vecs[i].pen, vecs[i].id, vecs[i].idx, vecs[i].done, vecs[i].err}) begin
                errors++;
                $display("FAIL vec%0d: got st=%0d pen=%0d id=%0d idx=%0d done=%0d err=%0d expected st=%0d pen=%0d id=%0d idx=%0d done=%0d err=%0d",
                         i, st0, pen0, id0, idx0, dn0, er0, vecs[i].st, vecs[i].pen,
                         vecs[i].id, vecs[i].idx, vecs[i].done, vecs[i].err);
            end
        end

        // Single message starting at the top ID
        do_reset();
        chk("one_rst_id", 32'(id1), 32'd15);
        step(1, 0, 0);
        chk("one_issue_pen", 32'(pen1), 32'd1);
        chk("one_issue_id", 32'(id1), 32'd15);
        step(0, 0, 0);
        chk("one_wait_state", 32'(st1), 32'd2);
        chk("one_wait_pen", 32'(pen1), 32'd0);
        step(0, 0, 1);
        chk("one_done_state", 32'(st1), 32'd3);
        chk("one_done", 32'(dn1), 32'd1);
        step(0, 0, 0);
        chk("one_idle_state", 32'(st1), 32'd0);
        chk("one_idle_done", 32'(dn1), 32'd0);

        // ID wrap 14,15,0
        do_reset();
        chk("wrap_rst_id", 32'(id2), 32'd14);
        step(1, 0, 0); chk2("wrap_i0", 3'd1, 1'b1, 4'd14, 1'b0, 1'b0);
        step(0, 0, 0); chk2("wrap_w0", 3'd2, 1'b0, 4'd14, 1'b0, 1'b0);
        step(0, 0, 1); chk2("wrap_i1", 3'd1, 1'b1, 4'd15, 1'b0, 1'b0);
        step(0, 0, 0); chk2("wrap_w1", 3'd2, 1'b0, 4'd15, 1'b0, 1'b0);
        step(0, 0, 1); chk2("wrap_i2", 3'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("wrap_idx2", 32'(idx2), 32'd2);
        step(0, 0, 0); chk2("wrap_w2", 3'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        step(0, 0, 1); chk2("wrap_done", 3'd3, 1'b0, 4'd0, 1'b1, 1'b0);
        step(0, 0, 0); chk2("wrap_idle", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Timeout: eight WAIT cycles, then ERROR held until enable drops
        step(1, 0, 0); chk2("to_issue", 3'd1, 1'b1, 4'd14, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0);
            chk($sformatf("to_wait%0d", k), 32'(st2), 32'd2);
        end
        step(1, 0, 0); chk2("to_err", 3'd4, 1'b0, 4'd14, 1'b0, 1'b1);
        step(1, 0, 0); chk2("to_hold1", 3'd4, 1'b0, 4'd14, 1'b0, 1'b1);
        step(1, 0, 0); chk2("to_hold2", 3'd4, 1'b0, 4'd14, 1'b0, 1'b1);
        step(0, 0, 0); chk2("to_idle", 3'd0, 1'b0, 4'd14, 1'b0, 1'b0);

        // printer_done on the timeout cycle wins
        step(1, 0, 0); chk2("race_issue", 3'd1, 1'b1, 4'd14, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(0, 0, 0);
        chk("race_pre_state", 32'(st2), 32'd2);
        step(0, 0, 1); chk2("race_win", 3'd1, 1'b1, 4'd15, 1'b0, 1'b0);
        step(0, 1, 0); chk2("race_abort", 3'd0, 1'b0, 4'd15, 1'b0, 1'b0);

        // Asynchronous reset during WAIT of the first message
        step(1, 0, 0);
        step(0, 0, 0);
        chk("ar_pre_state", 32'(st0), 32'd2);
        enable = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(st0), 32'd0);
        chk("ar_outs", 32'({pen0, id0, idx0, dn0, er0}), 32'd0);
        chk("ar_id2", 32'(id2), 32'd14);
        step(1, 0, 0);
        chk("ar_held_pen", 32'(pen0), 32'd0);
        chk("ar_held_state", 32'(st0), 32'd0);
        rst_n = 1'b1;
        step(1, 0, 0);
        chk("ar_restart_state", 32'(st0), 32'd1);
        chk("ar_restart_pen", 32'(pen0), 32'd1);
        chk("ar_restart_id", 32'(id0), 32'd0);
        step(0, 1, 0);
        chk("ar_final_state", 32'(st0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/print_seq.md
PRINT_SEQ -- requirements
Module: print_seq

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- STR_ID_W, 4: width of printer_str_id
- NUM_MSG, 3: strings printed per run (legal range 1..2^STR_ID_W)
- FIRST_ID, 0: string ID of the first message
- TIMEOUT_CYCLES, 0: WAIT-state cycle limit; 0 disables the timeout
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge
- rst_n, in, 1: asynchronous active-low reset
- enable, in, 1: start request (level, sampled in IDLE); also clears ERROR
- abort, in, 1: cancels the run in progress
- printer_done, in, 1: printer finished the current string
- printer_str_id, out, STR_ID_W: ID of the string being printed
- printer_enable, out, 1: one-cycle start pulse to the printer
- seq_state, out, 3: current state encoding
- seq_done, out, 1: run completed
- seq_error, out, 1: printer timeout occurred
- msg_index, out, clog2(NUM_MSG) (min 1): index of the current message

Function
REQ-003 States SHALL be IDLE=0, ISSUE=1, WAIT=2, DONE=3, ERROR=4; seq_state SHALL equal the state register directly.
REQ-004 In IDLE with enable=1 and abort=0, the next state SHALL be ISSUE, with msg_index<=0 and printer_str_id<=FIRST_ID.
REQ-005 printer_enable SHALL be registered and SHALL be 1 exactly during the ISSUE cycle: one pulse per message, never two consecutive cycles.
REQ-006 ISSUE SHALL always advance to WAIT after one cycle; the timeout counter SHALL clear to 0 on entry to WAIT.
REQ-007 printer_done SHALL be acted on only in WAIT; in every other state, including the ISSUE cycle, it SHALL be ignored.
REQ-008 In WAIT with printer_done=1 and msg_index<NUM_MSG-1: msg_index and printer_str_id SHALL each increment by 1, and the next state SHALL be ISSUE.
REQ-009 In WAIT with printer_done=1 and msg_index=NUM_MSG-1, the next state SHALL be DONE.
REQ-010 printer_str_id SHALL equal FIRST_ID+msg_index modulo 2^STR_ID_W; it SHALL wrap silently and hold its value outside ISSUE/WAIT transitions.
REQ-011 DONE SHALL last exactly one cycle with seq_done=1, then go to IDLE; seq_done SHALL be 0 in all other states.
REQ-012 If enable is still 1 in the IDLE cycle after DONE, a new run SHALL start (back-to-back runs are allowed).
REQ-013 With TIMEOUT_CYCLES>0, the counter SHALL increment each WAIT cycle without printer_done; on the cycle it equals TIMEOUT_CYCLES-1 with printer_done=0, the next state SHALL be ERROR.
REQ-014 If printer_done=1 on the timeout cycle, printer_done SHALL win.
REQ-015 With TIMEOUT_CYCLES=0, WAIT SHALL wait indefinitely and ERROR SHALL be unreachable.
REQ-016 ERROR SHALL hold seq_error=1 and SHALL go to IDLE on the first cycle with enable=0; seq_error SHALL be 0 in all other states.
REQ-017 abort=1 in ISSUE, WAIT, DONE or ERROR SHALL force IDLE next cycle, overriding all other transitions. printer_enable SHALL be 0 from that cycle, and seq_done/seq_error SHALL be deasserted.
REQ-018 abort=1 in IDLE SHALL block the start even when enable=1.
REQ-019 The timeout counter width SHALL be clog2(TIMEOUT_CYCLES+1) (min 1) and SHALL not wrap before the timeout fires.

Reset
REQ-020 While rst_n=0, the block SHALL force state=IDLE asynchronously, with msg_index=0, printer_str_id=FIRST_ID, printer_enable=0, seq_done=0, seq_error=0 and timeout counter=0.
REQ-021 Reset asserted mid-run SHALL abandon the run with no further printer_enable pulse.
REQ-022 After release, the block SHALL resume normal operation on the first rising edge with rst_n=1.

Verification
REQ-023 Defaults, enable pulse, printer_done 5 cycles after each pulse -> printer_enable pulses with str_id 0,1,2; seq_done high for 1 cycle; back to IDLE.
REQ-024 NUM_MSG=1, FIRST_ID=15, STR_ID_W=4 -> a single pulse with str_id 15; seq_done on the cycle after printer_done.
REQ-025 FIRST_ID=14, NUM_MSG=3 -> str_id sequence 14,15,0 (wrap).
REQ-026 TIMEOUT_CYCLES=8, printer never done -> ERROR entered 8 WAIT cycles after ISSUE; seq_error held until enable=0, then IDLE.
REQ-027 printer_done held high continuously and during ISSUE -> exactly one pulse per message and no skipped IDs; abort in WAIT of message 2 -> IDLE next cycle, no seq_done.
REQ-028 rst_n low during WAIT of message 1 -> all outputs at reset values immediately; a fresh enable restarts from FIRST_ID.
